// File: rtl/fetch_unit_32.sv
// Instruction fetch stage: owns the PC, runs a one-outstanding req/ack read to
// instruction memory and holds each fetched word in a registered output stage.
module fetch_unit_32 #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        inst_valid
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

   localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx, tgt, tgt_nx;
   logic        squash, squash_nx;
   logic        req_nx, vld_nx;
   logic [31:0] addr_nx, inst_nx, pco_nx, pcp4_nx;
   logic [31:0] rpc, pc_inc, ack_tgt;

   assign rpc     = {redirect_pc[31:2], 2'b00};
   assign pc_inc  = pc + 32'd4;
   // a redirect arriving with the ack overrides any target saved earlier
   assign ack_tgt = redirect_valid ? rpc : tgt;

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      tgt_nx    = tgt;
      squash_nx = squash;
      req_nx    = imem_req;
      addr_nx   = imem_addr;
      inst_nx   = instruction;
      pco_nx    = pc_out;
      pcp4_nx   = pc_plus4;
      vld_nx    = inst_valid;
      case (state)
         IDLE: begin
            state_nx = FETCH;
            req_nx   = 1'b1;
            addr_nx  = pc;
         end
         FETCH: begin
            if (imem_ack) begin
               if (redirect_valid || squash) begin
                  pc_nx     = ack_tgt;
                  addr_nx   = ack_tgt;
                  squash_nx = 1'b0;
                  req_nx    = 1'b1;
               end else begin
                  inst_nx  = imem_rdata;
                  pco_nx   = pc;
                  pcp4_nx  = pc_inc;
                  pc_nx    = pc_inc;
                  vld_nx   = 1'b1;
                  req_nx   = 1'b0;
                  state_nx = VALID;
               end
            end else if (redirect_valid) begin
               tgt_nx    = rpc;
               squash_nx = 1'b1;
            end
         end
         VALID: begin
            if (redirect_valid) begin
               vld_nx   = 1'b0;
               pc_nx    = rpc;
               addr_nx  = rpc;
               req_nx   = 1'b1;
               state_nx = FETCH;
            end else if (!stall) begin
               vld_nx   = 1'b0;
               addr_nx  = pc;
               req_nx   = 1'b1;
               state_nx = FETCH;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= PC0;
         tgt         <= PC0;
         squash      <= 1'b0;
         imem_req    <= 1'b0;
         imem_addr   <= PC0;
         instruction <= 32'h0;
         pc_out      <= 32'h0;
         pc_plus4    <= 32'h4;
         inst_valid  <= 1'b0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         tgt         <= tgt_nx;
         squash      <= squash_nx;
         imem_req    <= req_nx;
         imem_addr   <= addr_nx;
         instruction <= inst_nx;
         pc_out      <= pco_nx;
         pc_plus4    <= pcp4_nx;
         inst_valid  <= vld_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit_32.sv
// Directed bench for fetch_unit_32: inputs driven and outputs checked on the
// falling edge, expected values hand-computed.
module tb_fetch_unit_32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, redirect_valid, stall, inst_valid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_out, pc_plus4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit_32 #(.RESET_PC(32'h0040_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall),
      .instruction(instruction), .pc_out(pc_out), .pc_plus4(pc_plus4),
      .inst_valid(inst_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".req"},  {31'b0, imem_req},   32'h0);
      chk({tag, ".addr"}, imem_addr,           32'h0040_0000);
      chk({tag, ".inst"}, instruction,         32'h0);
      chk({tag, ".pc"},   pc_out,              32'h0);
      chk({tag, ".pc4"},  pc_plus4,            32'h4);
      chk({tag, ".vld"},  {31'b0, inst_valid}, 32'h0);
   endtask

   task automatic chk_req(input string tag, input logic [31:0] addr);
      chk({tag, ".req"},  {31'b0, imem_req},   32'h1);
      chk({tag, ".addr"}, imem_addr,           addr);
      chk({tag, ".vld"},  {31'b0, inst_valid}, 32'h0);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] pc4);
      chk({tag, ".vld"},  {31'b0, inst_valid}, 32'h1);
      chk({tag, ".req"},  {31'b0, imem_req},   32'h0);
      chk({tag, ".inst"}, instruction,         inst);
      chk({tag, ".pc"},   pc_out,              pc);
      chk({tag, ".pc4"},  pc_plus4,            pc4);
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
      nxt(); nxt();
      chk_rst("rst");

      // reset release, zero-latency memory
      rst_n = 1'b1;
      nxt();
      chk_req("boot", 32'h0040_0000);
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
      nxt();
      chk_out("boot_out", 32'h8C22_0004, 32'h0040_0000, 32'h0040_0004);
      imem_ack = 1'b0;
      nxt();
      chk_req("seq", 32'h0040_0004);

      // ack delayed 3 cycles: address held over all 4 request cycles
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk_req("slow", 32'h0040_0004);
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      nxt();
      chk_out("slow_out", 32'hDEAD_BEEF, 32'h0040_0004, 32'h0040_0008);

      // stall held 5 cycles
      imem_ack = 1'b0; stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         nxt();
         chk_out("stall", 32'hDEAD_BEEF, 32'h0040_0004, 32'h0040_0008);
      end
      stall = 1'b0;
      nxt();
      chk_req("unstall", 32'h0040_0008);

      // redirect during outstanding fetch, ack 2 cycles later
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      nxt();
      chk_req("sq_hold", 32'h0040_0008);
      redirect_valid = 1'b0;
      nxt();
      chk_req("sq_wait", 32'h0040_0008);
      imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      nxt();
      chk_req("sq_drop", 32'h0000_0100);
      imem_rdata = 32'h2222_2222;
      nxt();
      chk_out("sq_out", 32'h2222_2222, 32'h0000_0100, 32'h0000_0104);

      // redirect while VALID and stalled
      imem_ack = 1'b0; stall = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      nxt();
      chk_req("rv", 32'h0000_0200);
      chk("rv.inst", instruction, 32'h2222_2222);

      // redirect in the same cycle as ack
      stall = 1'b0; redirect_pc = 32'h0000_0300;
      imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
      nxt();
      chk_req("ra", 32'h0000_0300);
      redirect_valid = 1'b0; imem_rdata = 32'h4444_4444;
      nxt();
      chk_out("ra_out", 32'h4444_4444, 32'h0000_0300, 32'h0000_0304);

      // PC wrap at FFFFFFFC; low redirect bits ignored
      imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      nxt();
      chk_req("wrap_req", 32'hFFFF_FFFC);
      redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
      nxt();
      chk_out("wrap_out", 32'h5555_5555, 32'hFFFF_FFFC, 32'h0000_0000);
      imem_ack = 1'b0;
      nxt();
      chk_req("wrap_nxt", 32'h0000_0000);

      // several redirects before ack: last one wins
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
      nxt();
      redirect_pc = 32'h0000_0020;
      nxt();
      chk_req("multi_hold", 32'h0000_0000);
      redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
      nxt();
      chk_req("multi_drop", 32'h0000_0020);
      nxt();
      chk_out("multi_out", 32'h6666_6666, 32'h0000_0020, 32'h0000_0024);
      imem_ack = 1'b0;
      nxt();
      chk_req("pre_rst", 32'h0000_0024);

      // async reset mid-fetch, then a stray ack while IDLE
      #2 rst_n = 1'b0;
      #1 chk_rst("mid_rst");
      nxt();
      rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
      nxt();
      chk_req("stray", 32'h0040_0000);
      nxt();
      chk_out("post_rst", 32'h7777_7777, 32'h0040_0000, 32'h0040_0004);
      imem_ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
